// File: rtl/parity_pkg.sv
// Shared definitions for the even/odd parity frame scheme, used by both the
// transmit-side generator and the receive-side checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Expected parity bit given the XOR-reduction of the data word and the mode.
  // Even mode makes the total count of ones (data + parity) even, odd mode odd.
  function automatic logic exp_parity(input logic data_xor, input logic mode);
    return data_xor ^ mode;
  endfunction

endpackage

// File: rtl/parity_frame_rx.sv
// Serial receiver for LSB-first parity-protected frames:
// start (0), DATA_W data bits, parity bit, stop (1). Recovers the word,
// flags parity/framing errors and keeps a saturating error count.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              clear_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  rx_state_t         state;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic              par_q;
  logic              mode_q;
  logic              mismatch_q;

  assign busy = (state != IDLE);

  // Frame FSM: advances only on bit strobes; result flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      mode_q     <= PAR_EVEN;
      mismatch_q <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              mode_q <= mode;
              par_q  <= 1'b0;
              idx_q  <= '0;
              state  <= DATA;
            end
          end
          DATA: begin
            shift_q[idx_q] <= bit_in;
            par_q          <= par_q ^ bit_in;
            if (idx_q == LAST_IDX) begin
              state <= PARITY;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          PARITY: begin
            mismatch_q <= (bit_in != exp_parity(par_q, mode_q));
            state      <= STOP;
          end
          STOP: begin
            data_out   <= shift_q;
            parity_err <= mismatch_q;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturating error counter, bumped on the stop strobe of a bad frame so it
  // is visible alongside data_valid; a clear request always takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear_cnt) begin
      err_count <= '0;
    end else if (bit_valid && (state == STOP) && (mismatch_q || !bit_in) &&
                 (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: table of frames driven bit by bit,
// expected results queued on the stop strobe and compared when data_valid fires.
module tb_parity_frame_rx;

  localparam int DATA_W  = 4;
  localparam int CNT_W   = 2;
  localparam int FRAME_W = DATA_W + 3;

  logic              clk;
  logic              rst;
  logic              mode;
  logic              bit_valid;
  logic              bit_in;
  logic              clear_cnt;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  typedef struct {
    logic               mode;
    logic               flip;
    logic [FRAME_W-1:0] bits;
    int                 max_gap;
    logic               clr;
    exp_t               exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  parity_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clear_cnt  (clear_cnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mkBits(input logic start, input logic [DATA_W-1:0] d,
                                                  input logic par, input logic stop);
    return {stop, par, d, start};
  endfunction

  function automatic vec_t mkVec(input logic m, input logic flip, input logic [DATA_W-1:0] d,
                                 input logic par, input logic stop, input int gap, input logic clr,
                                 input logic perr, input logic ferr, input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.mode    = m;
    v.flip    = flip;
    v.bits    = mkBits(1'b0, d, par, stop);
    v.max_gap = gap;
    v.clr     = clr;
    v.exp     = '{data: d, perr: perr, ferr: ferr, cnt: cnt};
    return v;
  endfunction

  // Scoreboard: every data_valid pulse must match the oldest queued expectation,
  // and the error flags must stay low on every other cycle.
  always @(negedge clk) begin
    exp_t e;
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(data_valid), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("data_out", 32'(data_out), 32'(e.data));
        checkOutput("parity_err", 32'(parity_err), 32'(e.perr));
        checkOutput("frame_err", 32'(frame_err), 32'(e.ferr));
        checkOutput("err_count", 32'(err_count), 32'(e.cnt));
      end
    end else begin
      checkOutput("flags_without_valid", 32'({parity_err, frame_err}), 32'(0));
    end
  end

  // Drives one bit strobe; entered and left on a falling edge.
  task automatic strobe(input logic b, input logic clr);
    bit_in    = b;
    bit_valid = 1'b1;
    clear_cnt = clr;
    @(negedge clk);
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    bit_in    = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int gap;
    mode = v.mode;
    for (int i = 0; i < FRAME_W; i++) begin
      if (i == FRAME_W - 1) exp_q.push_back(v.exp);
      strobe(v.bits[i], (i == FRAME_W - 1) ? v.clr : 1'b0);
      if (i == 0 && v.flip) mode = ~v.mode;
      if (i < FRAME_W - 1) begin
        checkOutput("busy_in_frame", 32'(busy), 32'(1'b1));
        gap = $urandom_range(v.max_gap, 0);
        repeat (gap) begin
          @(negedge clk);
          checkOutput("busy_in_gap", 32'(busy), 32'(1'b1));
        end
      end
    end
    checkOutput("valid_latency", 32'(data_valid), 32'(1'b1));
    checkOutput("busy_after_stop", 32'(busy), 32'(1'b0));
    @(negedge clk);
    checkOutput("idle_after_frame", 32'(busy), 32'(1'b0));
    checkOutput("valid_single_cycle", 32'(data_valid), 32'(1'b0));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    clear_cnt = 1'b0;

    vecs[0] = mkVec(1'b0, 1'b0, 4'hB, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[1] = mkVec(1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 2'd1);
    vecs[2] = mkVec(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'd2);
    vecs[3] = mkVec(1'b0, 1'b0, 4'hB, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 2'd2);
    vecs[4] = mkVec(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 2'd3);
    vecs[5] = mkVec(1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 2'd3);
    vecs[6] = mkVec(1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 2'd0);
    vecs[7] = mkVec(1'b0, 1'b1, 4'hB, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[8] = mkVec(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[9] = mkVec(1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 2'd1);

    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", 32'(data_out), 32'(0));
    checkOutput("reset_valid", 32'(data_valid), 32'(0));
    checkOutput("reset_err_count", 32'(err_count), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] idle-line ones must not start a frame");
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    checkOutput("idle_ones_busy", 32'(busy), 32'(1'b0));

    for (int i = 0; i < 10; i++) begin
      $display("[TB] frame vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] reset in the middle of a frame");
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    checkOutput("abort_busy_before_rst", 32'(busy), 32'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'(1'b0));
    checkOutput("abort_err_count", 32'(err_count), 32'(0));
    checkOutput("abort_data_out", 32'(data_out), 32'(0));
    repeat (3) @(negedge clk);
    applyStimulus(vecs[0]);
    applyStimulus(vecs[9]);

    $display("[TB] standalone counter clear");
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    checkOutput("clear_idle", 32'(err_count), 32'(0));

    repeat (4) @(negedge clk);
    checkOutput("missing_valid_pulses", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
